// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by fetch, decode and the 64x16 RAM.
package cpu_pkg;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] HALT_WORD = 16'hFFFF;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 16-bit event counter; only built when INSTR_FETCH_PERF_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);
  logic [15:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC drives RAM read port, word captured into IR, valid/ready to decode.
// Optional INSTR_FETCH_PERF_EN adds a saturating fetch_count output.
module instr_fetch #(
  parameter int                           ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int                           DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]        RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]        HALT_WORD  = cpu_pkg::HALT_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  halted
`ifdef INSTR_FETCH_PERF_EN
  , output logic [15:0]         fetch_count
`endif
);
  import cpu_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d;
  logic [DATA_WIDTH-1:0] ir_data_q, ir_data_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  load, is_halt, fetch_ok;

  // A load requires the IR slot to be free or draining this edge; branches preempt it.
  assign load     = (state_q == RUN) && (!ir_valid_q || ir_ready) && !branch_valid;
  assign is_halt  = (mem_data == HALT_WORD);
  assign fetch_ok = load && !is_halt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (branch_valid)         state_d = RUN;
    else if (load && is_halt) state_d = HALTED;
  end

  always_comb begin
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    if (branch_valid) begin
      pc_d       = branch_target;
      ir_valid_d = 1'b0;
    end else if (load) begin
      ir_valid_d = !is_halt;
      if (!is_halt) begin
        ir_data_d = mem_data;
        ir_pc_d   = pc_q;
        pc_d      = pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    halted = (state_q == HALTED);
  end

  assign mem_addr = pc_q;
  assign ir_valid = ir_valid_q;
  assign ir_data  = ir_data_q;
  assign ir_pc    = ir_pc_q;

`ifdef INSTR_FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_ok),
    .count (fetch_count)
  );
`else
  logic unused_fetch_ok;
  assign unused_fetch_ok = fetch_ok;
`endif
endmodule
